// File: rtl/core_dbg_pkg.sv
// Shared encodings for the RV32I debug run/step controller.
package core_dbg_pkg;

  typedef enum logic [1:0] {
    HALTED = 2'd0,
    STEP   = 2'd1,
    RUN    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_USER  = 2'd1,
    CAUSE_COUNT = 2'd2,
    CAUSE_BP    = 2'd3
  } cause_e;

  // Breakpoint index width never collapses to zero bits for a single slot.
  function automatic int bp_idx_w(input int num_bp);
    return (num_bp > 1) ? $clog2(num_bp) : 1;
  endfunction

endpackage

// File: rtl/core_run_ctrl_if.sv
// Debug request / status bundle between the board buttons, the core and the VGA view.
interface core_run_ctrl_if
  import core_dbg_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NUM_BP = 4,
  parameter int CNT_W  = 16
) ();
  localparam int IDX_W = bp_idx_w(NUM_BP);

  logic                     step_req;
  logic                     run_req;
  logic                     halt_req;
  logic [CNT_W-1:0]         run_count;
  logic [NUM_BP*XLEN-1:0]   bp_pc;
  logic [NUM_BP-1:0]        bp_en;
  logic [XLEN-1:0]          pc;
  logic                     core_en;
  logic                     halted;
  logic                     running;
  logic [1:0]               halt_cause;
  logic [IDX_W-1:0]         bp_hit_idx;
  logic [31:0]              retired;

  modport master (
    output step_req, run_req, halt_req, run_count, bp_pc, bp_en, pc,
    input  core_en, halted, running, halt_cause, bp_hit_idx, retired
  );

  modport slave (
    input  step_req, run_req, halt_req, run_count, bp_pc, bp_en, pc,
    output core_en, halted, running, halt_cause, bp_hit_idx, retired
  );
endinterface

// File: rtl/core_run_ctrl_bp_compare.sv
// PC breakpoint comparators with a lowest-index-wins priority encoder.
module bp_compare
  import core_dbg_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NUM_BP = 4,
  parameter int IDX_W  = bp_idx_w(NUM_BP)
) (
  input  logic [XLEN-1:0]        pc,
  input  logic [NUM_BP*XLEN-1:0] bp_pc,
  input  logic [NUM_BP-1:0]      bp_en,
  output logic                   bp_match,
  output logic [IDX_W-1:0]       bp_idx
);

  // Scan from the top so the lowest matching slot is the last one written.
  always_comb begin
    bp_match = 1'b0;
    bp_idx   = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (pc == bp_pc[i*XLEN +: XLEN])) begin
        bp_match = 1'b1;
        bp_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/core_run_ctrl.sv
// Run/step/breakpoint controller producing the RV32I core clock enable.
module core_run_ctrl
  import core_dbg_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NUM_BP = 4,
  parameter int CNT_W  = 16
) (
  input logic            clk,
  input logic            reset,
  core_run_ctrl_if.slave dbg
);
  localparam int IDX_W = bp_idx_w(NUM_BP);

  state_e            state_q, state_d;
  cause_e            cause_q, cause_d;
  logic              step_q, run_q, halt_q;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              counted_q, counted_d;
  logic              first_q, first_d;
  logic [IDX_W-1:0]  bp_hit_idx_q, bp_hit_idx_d;
  logic [31:0]       retired_q, retired_d;
  logic              step_edge, run_edge, halt_edge;
  logic              bp_match;
  logic [IDX_W-1:0]  bp_idx;
  logic              core_en;

  bp_compare #(.XLEN(XLEN), .NUM_BP(NUM_BP), .IDX_W(IDX_W)) u_bp_compare (
    .pc       (dbg.pc),
    .bp_pc    (dbg.bp_pc),
    .bp_en    (dbg.bp_en),
    .bp_match (bp_match),
    .bp_idx   (bp_idx)
  );

  assign step_edge = dbg.step_req & ~step_q;
  assign run_edge  = dbg.run_req  & ~run_q;
  assign halt_edge = dbg.halt_req & ~halt_q;

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    remaining_d  = remaining_q;
    counted_d    = counted_q;
    first_d      = first_q;
    bp_hit_idx_d = bp_hit_idx_q;
    core_en      = 1'b0;
    unique case (state_q)
      HALTED: begin
        if (!halt_edge) begin
          if (step_edge) begin
            state_d = STEP;
          end else if (run_edge) begin
            state_d     = RUN;
            remaining_d = dbg.run_count;
            counted_d   = |dbg.run_count;
            first_d     = 1'b1;
          end
        end
      end
      STEP: begin
        core_en = 1'b1;
        state_d = HALTED;
        cause_d = CAUSE_NONE;
      end
      RUN: begin
        first_d = 1'b0;
        if (halt_edge) begin
          state_d = HALTED;
          cause_d = CAUSE_USER;
        end else if (bp_match && !first_q) begin
          // The first RUN cycle is exempt so a run can resume off a breakpoint PC.
          state_d      = HALTED;
          cause_d      = CAUSE_BP;
          bp_hit_idx_d = bp_idx;
        end else begin
          core_en = 1'b1;
          if (counted_q && (remaining_q == CNT_W'(1))) begin
            state_d = HALTED;
            cause_d = CAUSE_COUNT;
          end else if (counted_q) begin
            remaining_d = remaining_q - CNT_W'(1);
          end
        end
      end
      default: state_d = HALTED;
    endcase
    retired_d = retired_q + 32'(core_en);
  end

  // Edge-detect history resets high so a button held through reset never fires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= HALTED;
      cause_q      <= CAUSE_NONE;
      step_q       <= 1'b1;
      run_q        <= 1'b1;
      halt_q       <= 1'b1;
      remaining_q  <= '0;
      counted_q    <= 1'b0;
      first_q      <= 1'b0;
      bp_hit_idx_q <= '0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      step_q       <= dbg.step_req;
      run_q        <= dbg.run_req;
      halt_q       <= dbg.halt_req;
      remaining_q  <= remaining_d;
      counted_q    <= counted_d;
      first_q      <= first_d;
      bp_hit_idx_q <= bp_hit_idx_d;
      retired_q    <= retired_d;
    end
  end

  assign dbg.core_en    = core_en;
  assign dbg.halted     = (state_q == HALTED);
  assign dbg.running    = (state_q == RUN);
  assign dbg.halt_cause = cause_q;
  assign dbg.bp_hit_idx = bp_hit_idx_q;
  assign dbg.retired    = retired_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed-vector bench for core_run_ctrl with a tiny PC-advancing core model.
module tb_core_run_ctrl;
  localparam int XLEN   = 32;
  localparam int NUM_BP = 4;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic reset;
  logic pc_clr;
  int   n_vec  = 0;
  int   n_miss = 0;

  core_run_ctrl_if #(.XLEN(XLEN), .NUM_BP(NUM_BP), .CNT_W(CNT_W)) dbg ();

  core_run_ctrl #(.XLEN(XLEN), .NUM_BP(NUM_BP), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .dbg   (dbg)
  );

  always #5 clk = ~clk;

  // Core model: an enabled cycle retires one instruction and advances the PC by 4.
  always @(posedge clk) begin
    if (pc_clr)           dbg.pc <= '0;
    else if (dbg.core_en) dbg.pc <= dbg.pc + 32'd4;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_bp(input int slot, input logic [31:0] addr);
    dbg.bp_pc[slot*XLEN +: XLEN] = addr;
  endtask

  int en_cnt;

  initial begin
    reset         = 1'b1;
    pc_clr        = 1'b1;
    dbg.step_req  = 1'b1;
    dbg.run_req   = 1'b0;
    dbg.halt_req  = 1'b0;
    dbg.run_count = '0;
    dbg.bp_pc     = '0;
    dbg.bp_en     = '0;
    repeat (3) tick();
    chk("rst_core_en", 32'(dbg.core_en), 32'd0);
    reset  = 1'b0;
    pc_clr = 1'b0;

    // Step button held through reset must not produce a pulse.
    en_cnt = 0;
    repeat (4) begin tick(); en_cnt += int'(dbg.core_en); end
    chk("held_step_pulses", 32'(en_cnt), 32'd0);
    chk("rst_halted", 32'(dbg.halted), 32'd1);
    chk("rst_running", 32'(dbg.running), 32'd0);
    chk("rst_retired", dbg.retired, 32'd0);
    chk("rst_cause", 32'(dbg.halt_cause), 32'd0);
    chk("rst_bp_idx", 32'(dbg.bp_hit_idx), 32'd0);
    dbg.step_req = 1'b0;
    tick();

    // Single step; a run edge arriving during the STEP cycle is dropped.
    dbg.step_req = 1'b1;
    tick();
    chk("step_en", 32'(dbg.core_en), 32'd1);
    dbg.step_req = 1'b0;
    dbg.run_req  = 1'b1;
    tick();
    chk("step_en_after", 32'(dbg.core_en), 32'd0);
    chk("step_halted", 32'(dbg.halted), 32'd1);
    chk("step_retired", dbg.retired, 32'd1);
    chk("step_cause", 32'(dbg.halt_cause), 32'd0);
    tick();
    chk("step_run_ignored", 32'(dbg.running), 32'd0);
    dbg.run_req = 1'b0;
    tick();

    // Counted run of 5.
    pc_clr        = 1'b1;
    dbg.run_count = 16'd5;
    tick();
    pc_clr      = 1'b0;
    dbg.run_req = 1'b1;
    begin
      logic [7:0] trace;
      trace = '0;
      for (int i = 0; i < 8; i++) begin
        tick();
        trace[i] = dbg.core_en;
        dbg.run_req = 1'b0;
      end
      chk("cnt5_trace", 32'(trace), 32'h1F);
    end
    chk("cnt5_halted", 32'(dbg.halted), 32'd1);
    chk("cnt5_cause", 32'(dbg.halt_cause), 32'd2);
    chk("cnt5_retired", dbg.retired, 32'd6);

    // Unbounded run stopping on slot 2 at 0x10.
    pc_clr        = 1'b1;
    dbg.run_count = 16'd0;
    set_bp(2, 32'h10);
    dbg.bp_en     = 4'b0100;
    tick();
    pc_clr      = 1'b0;
    dbg.run_req = 1'b1;
    en_cnt = 0;
    repeat (4) begin tick(); en_cnt += int'(dbg.core_en); dbg.run_req = 1'b0; end
    chk("bp_pre_pulses", 32'(en_cnt), 32'd4);
    tick();
    chk("bp_match_pc", dbg.pc, 32'h10);
    chk("bp_match_en", 32'(dbg.core_en), 32'd0);
    tick();
    chk("bp_halted", 32'(dbg.halted), 32'd1);
    chk("bp_cause", 32'(dbg.halt_cause), 32'd3);
    chk("bp_idx2", 32'(dbg.bp_hit_idx), 32'd2);
    chk("bp_retired", dbg.retired, 32'd10);

    // Resume from the breakpoint PC with a 2-instruction run.
    dbg.run_count = 16'd2;
    dbg.run_req   = 1'b1;
    tick();
    chk("resume_first_en", 32'(dbg.core_en), 32'd1);
    dbg.run_req = 1'b0;
    repeat (2) tick();
    chk("resume_pc", dbg.pc, 32'h18);
    chk("resume_cause", 32'(dbg.halt_cause), 32'd2);
    chk("resume_retired", dbg.retired, 32'd12);

    // Slots 1 and 3 both match 0x20; lowest index wins.
    set_bp(1, 32'h20);
    set_bp(3, 32'h20);
    dbg.bp_en     = 4'b1010;
    dbg.run_count = 16'd0;
    dbg.run_req   = 1'b1;
    repeat (3) begin tick(); dbg.run_req = 1'b0; end
    chk("multi_match_en", 32'(dbg.core_en), 32'd0);
    tick();
    chk("multi_cause", 32'(dbg.halt_cause), 32'd3);
    chk("multi_idx", 32'(dbg.bp_hit_idx), 32'd1);
    chk("multi_retired", dbg.retired, 32'd14);

    // User halt coinciding with a breakpoint match reports a user halt.
    set_bp(0, 32'h28);
    dbg.bp_en   = 4'b0001;
    dbg.run_req = 1'b1;
    repeat (3) begin tick(); dbg.run_req = 1'b0; end
    chk("both_pc", dbg.pc, 32'h28);
    dbg.halt_req = 1'b1;
    #1;
    chk("both_en", 32'(dbg.core_en), 32'd0);
    tick();
    chk("both_halted", 32'(dbg.halted), 32'd1);
    chk("both_cause", 32'(dbg.halt_cause), 32'd1);
    chk("both_idx_kept", 32'(dbg.bp_hit_idx), 32'd1);
    dbg.halt_req = 1'b0;
    tick();

    // Reset asserted between edges in the middle of an unbounded run.
    dbg.bp_en   = '0;
    dbg.run_req = 1'b1;
    tick();
    dbg.run_req = 1'b0;
    tick();
    chk("midrun_en", 32'(dbg.core_en), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_core_en", 32'(dbg.core_en), 32'd0);
    chk("arst_halted", 32'(dbg.halted), 32'd1);
    chk("arst_running", 32'(dbg.running), 32'd0);
    chk("arst_retired", dbg.retired, 32'd0);
    chk("arst_cause", 32'(dbg.halt_cause), 32'd0);
    chk("arst_idx", 32'(dbg.bp_hit_idx), 32'd0);
    tick();
    reset = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Bounded run time in case the design wedges.
  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Run/step controller that gates the RV32I core's clock enable, replacing the raw button-pulse clocking with a free-running `clk`. It supports single-step, counted run, unbounded run and up to `NUM_BP` PC breakpoints. It reports halt state, halt cause and a retired-instruction count to the VGA debug view. It sits between the synchronised/debounced board buttons and the core top, and one enabled cycle retires exactly one instruction.

## Interface
Parameters:
- `XLEN`, 32: PC width.
- `NUM_BP`, 4: number of breakpoint comparators (1..16).
- `CNT_W`, 16: width of the run-count field.

Ports:
- `clk`  in  1: system clock. Single clock domain.
- `reset`  in  1: asynchronous, active-high reset.
- `step_req`  in  1: level input, already synchronised; rising edge requests one instruction.
- `run_req`  in  1: level input; rising edge starts a run.
- `halt_req`  in  1: level input; rising edge stops a run.
- `run_count`  in  CNT_W: instructions to execute per run. 0 means unbounded. Latched at run start.
- `bp_pc`  in  NUM_BP*XLEN: breakpoint addresses. Slot i is `[i*XLEN +: XLEN]`.
- `bp_en`  in  NUM_BP: per-slot enable.
- `pc`  in  XLEN: core's current PC, i.e. the instruction about to execute.
- `core_en`  out  1: core clock enable.
- `halted`  out  1: state is HALTED.
- `running`  out  1: state is RUN.
- `halt_cause`  out  2: 0 = reset/step, 1 = user halt, 2 = count done, 3 = breakpoint.
- `bp_hit_idx`  out  clog2(NUM_BP), minimum 1: slot that caused the last breakpoint halt.
- `retired`  out  32: count of `core_en` cycles.

## Operation
- Edge detect: `x_edge = x_req & ~x_q`, where `x_q` is the registered previous level.
  - `x_q` resets to 1, so a button held through reset does not fire.
- `bp_match`: true if any slot has `bp_en[i]` set and `pc == bp_pc[i]`. `bp_idx` is the lowest matching index.
- `first`: flag set on entry to RUN, cleared after the first RUN cycle.
- `core_en = (STEP) | (RUN & ~halt_edge & ~(bp_match & ~first))`.
- FSM states: HALTED, STEP, RUN.
- HALTED:
  - Request priority is halt > step > run. `halt_edge` is a no-op here.
  - `step_edge` goes to STEP.
  - `run_edge` goes to RUN. It loads `remaining = run_count` and sets `first`.
- STEP:
  - Lasts exactly one cycle, then returns to HALTED with `halt_cause = 0`.
  - All requests are ignored. Their edges are consumed, not queued.
  - Breakpoints are ignored.
- RUN, priority in order:
  - `halt_edge`: go to HALTED, cause 1.
  - Else `bp_match & ~first`: go to HALTED, cause 3, `bp_hit_idx <= bp_idx`.
  - Else if `run_count` was nonzero at entry and `remaining == 1`: go to HALTED, cause 2. This cycle's instruction still executes.
  - Else stay in RUN. Decrement `remaining` if in counted mode.
  - `step_edge` and `run_edge` are ignored.
- The `first` exemption lets a run resume from a PC sitting on an enabled breakpoint.
- `retired` increments on every `core_en` cycle and wraps modulo 2^32.

## Timing
- Reset values: state HALTED, `core_en` 0, `halted` 1, `running` 0, `halt_cause` 0, `bp_hit_idx` 0, `retired` 0, `remaining` 0, `first` 0.
- Reset asserted mid-run forces HALTED immediately. `core_en` drops asynchronously, because it decodes only reset-cleared state plus inputs.
- Request latency: request seen at edge k → `core_en` high from edge k to edge k+1 → core retires the instruction at edge k+1.
- Single step gives exactly one `core_en` cycle.
- Run with `run_count = N > 0` gives exactly N consecutive `core_en` cycles, unless interrupted.
- A breakpoint or halt stops the run with zero further instructions retired. `core_en` is low in the matching cycle.
- Breakpoint checks are combinational on `pc` in the same cycle. There is no pipeline.
- `bp_pc`, `bp_en` and `run_count` are sampled as live inputs. Only `run_count` is latched, at run start.

## Structure
- Shared package/include `core_dbg_pkg`:
  - state encoding HALTED=2'd0, STEP=2'd1, RUN=2'd2;
  - halt-cause codes CAUSE_NONE/CAUSE_USER/CAUSE_COUNT/CAUSE_BP.
- Sub-module `bp_compare`: NUM_BP equality comparators plus lowest-index priority encoder. Outputs `bp_match` and `bp_idx`.
- The FSM, `remaining` counter, edge detectors and `retired` counter stay in the top module.

## Test plan
- Reset held with `step_req=1`, then release → no `core_en` pulse. `halted=1`, `retired=0`.
- `step_req` rises once → `core_en` high for exactly 1 cycle, `retired=1`, `halt_cause=0`. A second step request within that STEP cycle is ignored.
- `run_count=5`, pulse `run_req` → 5 consecutive `core_en` cycles, then `halted=1`, `halt_cause=2`, `retired=5`.
- `run_count=0`, slot 2 enabled at 0x0000_0010, pc advancing by 4 from 0 → halt with pc=0x10, `core_en` low in that cycle, `halt_cause=3`, `bp_hit_idx=2`. Re-run → first instruction at 0x10 executes.
- Slots 1 and 3 both match → `bp_hit_idx=1`. `halt_req` and a breakpoint in the same cycle → `halt_cause=1`.
- Assert `reset` mid-run between clock edges → `core_en` falls before the next edge. All outputs take their reset values.
